// File: rtl/keypad_pass_entry_pkg.sv
// Shared definitions for the keypad password entry block.
//   - key code constants produced by the scanner
//   - scanner state encoding
//   - password length and small lookup helpers
package pass_pkg;

    localparam int PASS_DIGITS = 3;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_NONE = 4'hA;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REL_DB   = 2'd3
    } scan_state_t;

    // Index of the lowest active-low column; 0 when none is low.
    function automatic logic [1:0] lowest_col(input logic [3:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_n[c]) idx = 2'(c);
        end
        return idx;
    endfunction

    // Keypad layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    // Letter keys map to KEY_NONE so the entry logic ignores them.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_NONE;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_pass_entry_if.sv
// Password bus from the entry block to the comparator / 7-segment path.
//   o_password : BCD digits {d2,d1,d0}, newest in [3:0]
//   o_count    : digits entered, 0..3
//   o_en       : display enable (o_count != 0)
//   o_submit   : one-cycle pulse, o_password valid in that cycle
//   o_error    : one-cycle pulse, enter pressed with too few digits
//   dbg_state / dbg_key_valid : scanner state and accepted-key strobe
// Handshake: o_submit and o_error are single-cycle strobes with no ready;
// the consumer must sample o_password in the o_submit cycle.
import pass_pkg::*;

interface keypad_pass_entry_if;
    logic [11:0] o_password;
    logic [1:0]  o_count;
    logic        o_en;
    logic        o_submit;
    logic        o_error;
    scan_state_t dbg_state;
    logic        dbg_key_valid;

    modport master (
        output o_password, o_count, o_en, o_submit, o_error, dbg_state, dbg_key_valid
    );
    modport slave (
        input o_password, o_count, o_en, o_submit, o_error, dbg_state, dbg_key_valid
    );
endinterface

// File: rtl/keypad_pass_entry_scanner.sv
// 4x4 matrix keypad scanner with press and release debounce.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_col          : raw column sense, active-low
//   o_row          : row drive, one-hot active-low
//   o_key_valid    : one-cycle strobe per debounced press
//   o_key_code     : code of the latched key (valid with o_key_valid)
//   o_state        : current FSM state
import pass_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_col,
    output logic [3:0]  o_row,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output scan_state_t o_state
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

    scan_state_t state, next_state;

    logic [1:0]       row_idx, row_d1, row_d2;
    logic [3:0]       col_s1, col_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [DB_W-1:0]  db_cnt;
    logic [1:0]       lat_row, lat_col;

    logic       any_low, aligned, lat_low, same_key, db_done;
    logic [1:0] low_idx;

    // row_d2 is the row that was driven when the sample now in col_s2 was
    // taken, so detection and debounce always pair a sample with its row.
    assign any_low  = (col_s2 != 4'hF);
    assign low_idx  = lowest_col(col_s2);
    assign aligned  = (row_d2 == lat_row);
    assign lat_low  = !col_s2[lat_col];
    assign same_key = any_low && (low_idx == lat_col);
    assign db_done  = (db_cnt == DB_W'(DEBOUNCE_CNT));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_SCAN;
        else          state <= next_state;
    end

    // Next-state logic; samples from a row other than the latched one
    // (pipeline still settling) are neither counted nor acted on.
    always_comb begin
        next_state = state;
        case (state)
            ST_SCAN: begin
                if (any_low) next_state = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (aligned) begin
                    if (!same_key)    next_state = ST_SCAN;
                    else if (db_done) next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (aligned && !lat_low) next_state = ST_REL_DB;
            end
            ST_REL_DB: begin
                if (aligned) begin
                    if (lat_low)      next_state = ST_HOLD;
                    else if (db_done) next_state = ST_SCAN;
                end
            end
            default: next_state = ST_SCAN;
        endcase
    end

    // Outputs
    always_comb begin
        o_row       = ~(4'b0001 << row_idx);
        o_key_code  = key_lookup(lat_row, lat_col);
        o_key_valid = (state == ST_PRESS_DB) && aligned && same_key && db_done;
        o_state     = state;
    end

    // Synchroniser, row rotation, latch and debounce counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_s1  <= 4'hF;
            col_s2  <= 4'hF;
            row_idx <= 2'd0;
            row_d1  <= 2'd0;
            row_d2  <= 2'd0;
            div_cnt <= '0;
            db_cnt  <= '0;
            lat_row <= 2'd0;
            lat_col <= 2'd0;
        end else begin
            col_s1 <= i_col;
            col_s2 <= col_s1;
            row_d1 <= row_idx;
            row_d2 <= row_d1;
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        // Jump the drive back to the row that produced the hit
                        lat_row <= row_d2;
                        lat_col <= low_idx;
                        row_idx <= row_d2;
                        div_cnt <= '0;
                        db_cnt  <= '0;
                    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                        row_idx <= row_idx + 2'd1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_PRESS_DB: begin
                    if (aligned && same_key && !db_done) db_cnt <= db_cnt + 1'b1;
                end
                ST_HOLD: begin
                    db_cnt <= '0;
                end
                ST_REL_DB: begin
                    if (aligned && !lat_low && !db_done) db_cnt <= db_cnt + 1'b1;
                end
                default: db_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/keypad_pass_entry.sv
// Password entry front end: scans the keypad and builds a 3-digit BCD
// password for the lock comparator and 7-segment display.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_col          : keypad column sense, active-low
//   o_row          : keypad row drive, one-hot active-low
//   pass_bus       : password, digit count, display enable, submit/error
import pass_pkg::*;

module keypad_pass_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [3:0]                 i_col,
    output logic [3:0]                 o_row,
    keypad_pass_entry_if.master        pass_bus
);

    logic        key_valid;
    logic [3:0]  key_code;
    scan_state_t scan_state;

    logic [11:0] password;
    logic [1:0]  count;
    logic        submit, error;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_scanner (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_col       (i_col),
        .o_row       (o_row),
        .o_key_valid (key_valid),
        .o_key_code  (key_code),
        .o_state     (scan_state)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            password <= '0;
            count    <= '0;
            submit   <= 1'b0;
            error    <= 1'b0;
        end else begin
            submit <= 1'b0;
            error  <= 1'b0;
            if (submit) begin
                // Password held through the submit cycle, cleared after it
                password <= '0;
                count    <= '0;
            end else if (key_valid) begin
                if (key_code <= KEY_9) begin
                    if (count < 2'(PASS_DIGITS)) begin
                        password <= {password[7:0], key_code};
                        count    <= count + 2'd1;
                    end
                end else if (key_code == KEY_STAR) begin
                    password <= '0;
                    count    <= '0;
                end else if (key_code == KEY_HASH) begin
                    if (count == 2'(PASS_DIGITS)) begin
                        submit <= 1'b1;
                    end else begin
                        error    <= 1'b1;
                        password <= '0;
                        count    <= '0;
                    end
                end
            end
        end
    end

    assign pass_bus.o_password    = password;
    assign pass_bus.o_count       = count;
    assign pass_bus.o_en          = (count != 2'd0);
    assign pass_bus.o_submit      = submit;
    assign pass_bus.o_error       = error;
    assign pass_bus.dbg_state     = scan_state;
    assign pass_bus.dbg_key_valid = key_valid;

endmodule

// File: tb/tb_keypad_pass_entry.sv
// Directed bench for keypad_pass_entry with a behavioural keypad.
module tb_keypad_pass_entry;
    import pass_pkg::*;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: pulls the key's column low while its row is driven
    logic       key_down = 1'b0;
    logic [1:0] key_row  = 2'd0;
    logic [1:0] key_col  = 2'd0;
    logic [3:0] col;
    logic [3:0] row;
    always_comb col = (key_down && row[key_row] == 1'b0) ? ~(4'b0001 << key_col) : 4'hF;

    keypad_pass_entry_if bus();

    keypad_pass_entry #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_col    (col),
        .o_row    (row),
        .pass_bus (bus.master)
    );

    // Scoreboard counters
    int          n_checks = 0;
    int          n_fail   = 0;
    int          kv_cnt   = 0;
    int          sub_cnt  = 0;
    int          err_cnt  = 0;
    logic [11:0] sub_pw   = '0;
    logic [11:0] err_pw   = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dbg_key_valid) kv_cnt++;
            if (bus.o_submit) begin
                sub_cnt++;
                sub_pw = bus.o_password;
            end
            if (bus.o_error) begin
                err_cnt++;
                err_pw = bus.o_password;
            end
        end
    end

    // Driver: press, wait for acceptance + entry update, release, settle
    task automatic press(input logic [1:0] r, input logic [1:0] c);
        logic got;
        got      = 1'b0;
        key_row  = r;
        key_col  = c;
        key_down = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.dbg_key_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("press_accepted", 32'(got), 32'd1);
        @(negedge clk);
        repeat (4) @(negedge clk);
        key_down = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic expect_entry(input string tag, input logic [11:0] pw, input logic [1:0] cnt);
        check({tag, "_pw"}, 32'(bus.o_password), 32'(pw));
        check({tag, "_cnt"}, 32'(bus.o_count), 32'(cnt));
        check({tag, "_en"}, 32'(bus.o_en), 32'(cnt != 2'd0));
    endtask

    initial begin
        int s0, e0, k0, lat;
        logic found;

        // 1. Reset values and row rotation
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row), 32'h0000000E);
        expect_entry("rst", 12'h000, 2'd0);
        check("rst_submit", 32'(bus.o_submit), 32'd0);
        check("rst_error", 32'(bus.o_error), 32'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            logic [3:0] exp_row;
            @(negedge clk);
            exp_row = ~(4'b0001 << (e / 4));
            check($sformatf("rotate_%0d", e), 32'(row), 32'(exp_row));
        end

        // 2. 1, 2, 3, # -> submit
        press(2'd0, 2'd0); expect_entry("d1", 12'h001, 2'd1);
        press(2'd0, 2'd1); expect_entry("d12", 12'h012, 2'd2);
        press(2'd0, 2'd2); expect_entry("d123", 12'h123, 2'd3);
        s0 = sub_cnt;
        press(2'd3, 2'd2);
        check("submit_pulses", 32'(sub_cnt - s0), 32'd1);
        check("submit_pw", 32'(sub_pw), 32'h123);
        expect_entry("after_submit", 12'h000, 2'd0);

        // 3. 4, 5, 6, 7 -> 7 ignored
        press(2'd1, 2'd0);
        press(2'd1, 2'd1);
        press(2'd1, 2'd2);
        press(2'd2, 2'd0);
        expect_entry("no_wrap", 12'h456, 2'd3);
        press(2'd3, 2'd0);
        expect_entry("star_clear", 12'h000, 2'd0);

        // 4. Bouncing contact on 9, then stable
        k0       = kv_cnt;
        key_row  = 2'd2;
        key_col  = 2'd2;
        for (int i = 0; i < 5; i++) begin
            key_down = 1'b1;
            repeat (3) @(negedge clk);
            key_down = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("bounce_no_key", 32'(kv_cnt - k0), 32'd0);
        key_down = 1'b1;
        repeat (200) @(negedge clk);
        key_down = 1'b0;
        repeat (30) @(negedge clk);
        check("bounce_one_key", 32'(kv_cnt - k0), 32'd1);
        expect_entry("bounce", 12'h009, 2'd1);
        press(2'd3, 2'd0);

        // 5. 8, 0, # -> error; then 5, 5, * -> cleared
        press(2'd2, 2'd1);
        press(2'd3, 2'd1);
        expect_entry("d80", 12'h080, 2'd2);
        s0 = sub_cnt;
        e0 = err_cnt;
        press(2'd3, 2'd2);
        check("error_pulses", 32'(err_cnt - e0), 32'd1);
        check("error_no_submit", 32'(sub_cnt - s0), 32'd0);
        check("error_pw_cleared", 32'(err_pw), 32'h000);
        expect_entry("after_error", 12'h000, 2'd0);
        press(2'd1, 2'd1);
        press(2'd1, 2'd1);
        expect_entry("d55", 12'h055, 2'd2);
        press(2'd3, 2'd0);
        expect_entry("d55_star", 12'h000, 2'd0);

        // 6. Reset during PRESS_DB with 2 digits entered
        press(2'd0, 2'd0);
        press(2'd0, 2'd1);
        expect_entry("pre_rst", 12'h012, 2'd2);
        key_row  = 2'd0;
        key_col  = 2'd2;
        key_down = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.dbg_state == ST_PRESS_DB) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_press_db", 32'(found), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_row", 32'(row), 32'h0000000E);
        check("async_rst_state", 32'(bus.dbg_state), 32'(ST_SCAN));
        expect_entry("async_rst", 12'h000, 2'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lat   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.dbg_key_valid) break;
        end
        check("redetect_latency", 32'(lat), 32'd11);
        @(negedge clk);
        expect_entry("redetect", 12'h003, 2'd1);
        key_down = 1'b0;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_pass_entry.md
Name: keypad_pass_entry

Overview:
- Password entry front end for the door lock; it is the input side of the 7-segment password decoder.
- Scans a 4x4 matrix keypad, debounces presses and accumulates three decimal digits into a 12-bit BCD password (3 nibbles).
- Presents the in-progress password and display enable for the 7-segment path, and pulses submit or error on the enter key.
- Downstream, the comparator consumes o_password on o_submit; the display decoder uses o_password and o_en.

Parameters:
- SCAN_DIV, 1000: clock cycles each keypad row is driven before advancing to the next row (minimum 2).
- DEBOUNCE_CNT, 20000: consecutive identical samples required to accept a press and, separately, a release (minimum 2).

Ports:
- i_clk  input  1  system clock; the block has a single clock domain.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_col  input  4  keypad column sense, active-low, pulled up externally; synchronised internally by 2 flops.
- o_row  output  4  keypad row drive, one-hot active-low.
- o_password  output  12  BCD digits {d2,d1,d0}; the newest digit is in [3:0].
- o_count  output  2  number of digits entered, 0..3.
- o_en  output  1  display enable; 1 whenever o_count != 0.
- o_submit  output  1  one-cycle pulse when a 3-digit password is entered.
- o_error  output  1  one-cycle pulse when enter is pressed with fewer than 3 digits.

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - o_row=4'b1110, o_password=0, o_count=0, o_en=0, o_submit=0, o_error=0.
  - Scanner goes to SCAN; all counters are cleared.
- Key layout, indexed by row r and column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - A–D are ignored.
  - If several columns are low, the lowest column index wins.
- Scanner FSM:
  - SCAN:
    - Rotates the active row r0→r1→r2→r3→r0, advancing every SCAN_DIV cycles.
    - If any synchronised column is low, it latches (row, col), freezes the rotation and goes to PRESS_DB.
  - PRESS_DB:
    - Counts cycles while the latched column stays low.
    - If the column goes high, or a different lowest column appears, it returns to SCAN and restarts rotation from the current row.
    - When the count reaches DEBOUNCE_CNT, it asserts key_valid for 1 cycle with key_code and goes to HOLD.
  - HOLD:
    - Waits for the latched column to go high; goes to REL_DB on the first high sample.
  - REL_DB:
    - Counts cycles while the column stays high; any low sample returns to HOLD.
    - At DEBOUNCE_CNT, it goes to SCAN.
  - Outcome: exactly one key_valid per physical press, with no auto-repeat.
- Entry logic, registered and updated on the cycle after key_valid:
  - Digit with o_count<3: o_password <= {o_password[7:0], digit}; o_count increments by 1.
  - Digit with o_count==3: ignored. There is no wrap and no overwrite.
  - Key "*": o_password=0, o_count=0.
  - Key "#" with o_count==3: o_submit=1 for one cycle, with o_password still holding the entered value in that cycle. On the following cycle o_password=0 and o_count=0.
  - Key "#" with o_count<3: o_error=1 for one cycle; the password and count clear in the same cycle.
- Latency from column-low to key_valid: 2 (synchroniser) + 1 (detect) + DEBOUNCE_CNT cycles.
  - The o_password update follows 1 cycle later.
- Reset mid-operation: all state aborts immediately. After reset deassertion, a key still held is re-detected and fully debounced again as a new press.

Decomposition:
- Package pass_pkg holds:
  - key code constants KEY_0..KEY_9 = 4'h0..4'h9, KEY_STAR = 4'hE, KEY_HASH = 4'hF, KEY_NONE = 4'hA;
  - the scanner state encoding;
  - PASS_DIGITS = 3.
- Sub-module keypad_scanner holds the row drive, synchroniser, FSM and debounce counter, and outputs key_valid and key_code[3:0].
- keypad_pass_entry instantiates keypad_scanner and holds the entry register, the counters and the pulse outputs.

Test Plan:
Benches use SCAN_DIV=4 and DEBOUNCE_CNT=8, with a keypad model that pulls i_col low when the pressed key's row is driven.
1. Hold reset low, then release → o_row=4'b1110, all other outputs 0; o_row rotates with a 4-cycle period.
2. Press 1, 2, 3, then # → o_password 12'h001, 12'h012, 12'h123 and o_count 1, 2, 3; o_submit is high for exactly 1 cycle with o_password=12'h123, then o_password=0, o_count=0, o_en=0.
3. Press 4, 5, 6, 7 → o_password=12'h456 and o_count=3; the 7 is ignored.
4. Column toggles every 3 cycles for 30 cycles, then stays stable on key 9 for 200 cycles → exactly one key_valid; o_password=12'h009, o_count=1.
5. Press 8, 0, then # → o_error pulses for 1 cycle, o_submit stays 0, then o_password=0 and o_count=0. Separately, press 5, 5, then * → cleared.
6. Assert i_rst_n low during PRESS_DB with 2 digits entered → outputs reset asynchronously. After release with the key still held, one new digit is accepted after full debounce.
